// File: rtl/seq_comp.sv
// seq_comp: sequential magnitude comparator. Walks the operands CHUNK bits per
// cycle from the most significant chunk down and stops at the first chunk that
// differs. In signed mode only the top chunk carries the sign, so only that
// chunk is compared as two's complement.
module seq_comp #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [KW-1:0]    K_TOP    = KW'(N - 1);
  localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sm;
  logic [KW-1:0]    r_k;
  logic             r_eq;
  logic             r_lt;
  logic             r_gt;

  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic [CHUNK-1:0] w_ca_x;
  logic [CHUNK-1:0] w_cb_x;
  logic             w_flip;
  logic             w_lt;
  logic             w_gt;

  // Current chunk select. Signed ordering of the top chunk is obtained by
  // inverting its sign bit and then comparing unsigned.
  always_comb begin
    w_ca   = CHUNK'(r_a >> (32'(r_k) * CHUNK));
    w_cb   = CHUNK'(r_b >> (32'(r_k) * CHUNK));
    w_flip = r_sm && (r_k == K_TOP);
    w_ca_x = w_ca ^ (w_flip ? MSB_MASK : '0);
    w_cb_x = w_cb ^ (w_flip ? MSB_MASK : '0);
    w_lt   = (w_ca_x < w_cb_x);
    w_gt   = (w_ca_x > w_cb_x);
  end

  // Control FSM plus operand/result registers; reset wins over start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sm    <= 1'b0;
      r_k     <= '0;
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
      r_gt    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_sm    <= signed_mode;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
            r_gt    <= 1'b0;
            r_k     <= K_TOP;
            r_state <= S_CMP;
          end
        end
        S_CMP: begin
          if (w_lt) begin
            r_lt    <= 1'b1;
            r_state <= S_DONE;
          end else if (w_gt) begin
            r_gt    <= 1'b1;
            r_state <= S_DONE;
          end else if (r_k == '0) begin
            r_eq    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_k <= r_k - 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state == S_CMP) || (r_state == S_DONE);
  assign done = (r_state == S_DONE);
  assign eq   = r_eq;
  assign lt   = r_lt;
  assign gt   = r_gt;

endmodule
